// File: rtl/cache_axi_bridge_pkg.sv
// cache_axi_pkg: shared types and constants for the cache-to-AXI bridge.
//   - read/write FSM state enumerations
//   - AXI burst/size encodings and ID width
//   - idx_w(): index width for an N-entry selector (at least 1 bit)
package cache_axi_pkg;

  localparam int          ID_W       = 4;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    W_DONE = 3'd4
  } wr_state_e;

  // Index width for N entries; a single entry still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: AXI read/write channel bundle between the bridge
// (master modport) and the memory system (slave modport).
//   AR: ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_valid -> , <- ar_ready
//   R : <- r_id/r_data/r_last/r_valid, r_ready ->
//   AW: aw_addr/aw_len/aw_size/aw_burst/aw_valid -> , <- aw_ready
//   W : w_data/w_strb/w_last/w_valid -> , <- w_ready
//   B : <- b_valid, b_ready ->
interface cache_axi_bridge_if;
  import cache_axi_pkg::*;

  logic [ID_W-1:0] ar_id;
  logic [31:0]     ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic            ar_valid;
  logic            ar_ready;

  logic [ID_W-1:0] r_id;
  logic [31:0]     r_data;
  logic            r_last;
  logic            r_valid;
  logic            r_ready;

  logic [31:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            aw_valid;
  logic            aw_ready;

  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;

  logic            b_valid;
  logic            b_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    output aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output w_data, w_strb, w_last, w_valid, b_ready,
    input  ar_ready, r_id, r_data, r_last, r_valid, aw_ready, w_ready, b_valid
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    input  aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  w_data, w_strb, w_last, w_valid, b_ready,
    output ar_ready, r_id, r_data, r_last, r_valid, aw_ready, w_ready, b_valid
  );

endinterface

// File: rtl/cache_axi_bridge_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or
// after ptr_i, wrapping at N.
//   req_i     in  N   request vector
//   ptr_i     in  IW  priority pointer
//   gnt_oh_o  out N   one-hot grant (zero when no request)
//   gnt_idx_o out IW  index of the granted requester
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic found_s;
  int   cand_s;

  // Scan N candidates starting at the pointer and keep the first requester.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int i = 0; i < N; i++) begin
      cand_s = (int'(ptr_i) + i) % N;
      if (!found_s && req_i[cand_s]) begin
        found_s          = 1'b1;
        gnt_idx_o        = IW'(cand_s);
        gnt_oh_o[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: serves N_RD cache line-fill clients and one write client
// over AXI. Read and write FSMs run independently; one read outstanding.
//   aclk, aresetn              clock, async active-low reset
//   axi (master)               AXI AR/R/AW/W/B channels
//   c_raddr/c_rlen/c_rsize     per-client read request fields (slice k)
//   c_rvalid / c_rready        per-client request / one-cycle completion
//   c_rdata                    returned line (beat k at [32k+31:32k])
//   d_w* / d_wvalid / d_wready write request / one-cycle completion
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int N_RD       = 2,
  parameter int LINE_BEATS = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  cache_axi_bridge_if.master       axi,
  input  logic [N_RD*32-1:0]       c_raddr,
  input  logic [N_RD*8-1:0]        c_rlen,
  input  logic [N_RD*3-1:0]        c_rsize,
  input  logic [N_RD-1:0]          c_rvalid,
  output logic [N_RD-1:0]          c_rready,
  output logic [LINE_BEATS*32-1:0] c_rdata,
  input  logic [31:0]              d_waddr,
  input  logic [LINE_BEATS*32-1:0] d_wdata,
  input  logic [7:0]               d_wlen,
  input  logic [2:0]               d_wsize,
  input  logic [3:0]               d_wstrb,
  input  logic                     d_wvalid,
  output logic                     d_wready
);

  localparam int              IW      = idx_w(N_RD);
  localparam int              CW      = $clog2(LINE_BEATS) + 1;
  localparam logic [N_RD-1:0] ONE_HOT = N_RD'(1);
  localparam logic [CW-1:0]   BEATS_C = CW'(LINE_BEATS);

  function automatic logic [31:0] beat_of(input logic [LINE_BEATS*32-1:0] line,
                                          input logic [7:0] idx);
    if (int'(idx) < LINE_BEATS) begin
      return line[int'(idx)*32 +: 32];
    end else begin
      return 32'd0;
    end
  endfunction

  // ---------------- read side ----------------
  rd_state_e             r_state_q;
  logic [IW-1:0]         grant_q, rr_ptr_q, gnt_idx_s;
  logic [N_RD-1:0]       gnt_oh_s;
  logic [CW-1:0]         cnt_q;
  logic [LINE_BEATS*32-1:0] line_q;
  logic                  ar_valid_q, r_ready_q;
  logic [ID_W-1:0]       ar_id_q;
  logic [31:0]           ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [N_RD-1:0]       c_rready_q;
  logic                  unused_rid_s;

  rr_arbiter #(.N(N_RD), .IW(IW)) u_arb (
    .req_i     (c_rvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Read FSM: grant, AR handshake, fill line buffer, completion pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q  <= R_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= 32'd0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      r_ready_q  <= 1'b0;
      c_rready_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (|gnt_oh_s) begin
            grant_q    <= gnt_idx_s;
            ar_id_q    <= ID_W'(gnt_idx_s);
            ar_addr_q  <= c_raddr[int'(gnt_idx_s)*32 +: 32];
            ar_len_q   <= c_rlen[int'(gnt_idx_s)*8 +: 8];
            ar_size_q  <= c_rsize[int'(gnt_idx_s)*3 +: 3];
            ar_burst_q <= BURST_INCR;
            ar_valid_q <= 1'b1;
            cnt_q      <= '0;
            line_q     <= '0;
            r_state_q  <= R_ADDR;
          end else begin
            r_state_q <= R_IDLE;
          end
        end
        R_ADDR: begin
          if (axi.ar_ready) begin
            // AR fields read zero outside the address phase.
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= 32'd0;
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_ready_q  <= 1'b1;
            r_state_q  <= R_DATA;
          end else begin
            r_state_q <= R_ADDR;
          end
        end
        R_DATA: begin
          if (axi.r_valid) begin
            // Beats past the line are dropped; cnt stops at LINE_BEATS.
            if (cnt_q < BEATS_C) begin
              line_q[int'(cnt_q)*32 +: 32] <= axi.r_data;
              cnt_q <= cnt_q + CW'(1);
            end else begin
              cnt_q <= cnt_q;
            end
            if (axi.r_last) begin
              r_ready_q  <= 1'b0;
              c_rready_q <= ONE_HOT << grant_q;
              r_state_q  <= R_DONE;
            end else begin
              r_state_q <= R_DATA;
            end
          end else begin
            r_state_q <= R_DATA;
          end
        end
        R_DONE: begin
          c_rready_q <= '0;
          rr_ptr_q   <= (grant_q == IW'(N_RD - 1)) ? '0 : grant_q + IW'(1);
          r_state_q  <= R_IDLE;
        end
        default: begin
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign unused_rid_s = ^axi.r_id;

  // ---------------- write side ----------------
  wr_state_e                w_state_q;
  logic [LINE_BEATS*32-1:0] wdata_q;
  logic [7:0]               wlen_q, wcnt_q;
  logic [1:0]               woff_q;
  logic [3:0]               wstrb_in_q;
  logic                     aw_valid_q, w_valid_q, w_last_q, b_ready_q, d_wready_q;
  logic [31:0]              aw_addr_q, w_data_q;
  logic [7:0]               aw_len_q;
  logic [2:0]               aw_size_q;
  logic [1:0]               aw_burst_q;
  logic [3:0]               w_strb_q;

  // Write FSM: latch request, AW handshake, stream beats, wait for B.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q  <= W_IDLE;
      wdata_q    <= '0;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      woff_q     <= 2'd0;
      wstrb_in_q <= 4'd0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= 32'd0;
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'd0;
      w_strb_q   <= 4'd0;
      w_last_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      d_wready_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (d_wvalid) begin
            wdata_q    <= d_wdata;
            wlen_q     <= d_wlen;
            woff_q     <= d_waddr[1:0];
            wstrb_in_q <= d_wstrb;
            wcnt_q     <= 8'd0;
            aw_valid_q <= 1'b1;
            aw_addr_q  <= d_waddr;
            aw_len_q   <= d_wlen;
            aw_size_q  <= d_wsize;
            aw_burst_q <= BURST_INCR;
            w_state_q  <= W_ADDR;
          end else begin
            w_state_q <= W_IDLE;
          end
        end
        W_ADDR: begin
          if (axi.aw_ready) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= 32'd0;
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_valid_q  <= 1'b1;
            // A single-beat write is byte-lane aligned to the address offset.
            if (wlen_q == 8'd0) begin
              w_data_q <= beat_of(wdata_q, 8'd0) << {woff_q, 3'b000};
              w_strb_q <= wstrb_in_q << woff_q;
              w_last_q <= 1'b1;
            end else begin
              w_data_q <= beat_of(wdata_q, 8'd0);
              w_strb_q <= 4'hF;
              w_last_q <= 1'b0;
            end
            w_state_q <= W_DATA;
          end else begin
            w_state_q <= W_ADDR;
          end
        end
        W_DATA: begin
          if (axi.w_ready) begin
            if (w_last_q) begin
              w_valid_q <= 1'b0;
              w_data_q  <= 32'd0;
              w_strb_q  <= 4'd0;
              w_last_q  <= 1'b0;
              b_ready_q <= 1'b1;
              w_state_q <= W_RESP;
            end else begin
              wcnt_q    <= wcnt_q + 8'd1;
              w_data_q  <= beat_of(wdata_q, wcnt_q + 8'd1);
              w_strb_q  <= 4'hF;
              w_last_q  <= ((wcnt_q + 8'd1) == wlen_q);
              w_state_q <= W_DATA;
            end
          end else begin
            w_state_q <= W_DATA;
          end
        end
        W_RESP: begin
          if (axi.b_valid) begin
            b_ready_q  <= 1'b0;
            d_wready_q <= 1'b1;
            w_state_q  <= W_DONE;
          end else begin
            w_state_q <= W_RESP;
          end
        end
        W_DONE: begin
          d_wready_q <= 1'b0;
          w_state_q  <= W_IDLE;
        end
        default: begin
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  assign axi.ar_id    = ar_id_q;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_len   = ar_len_q;
  assign axi.ar_size  = ar_size_q;
  assign axi.ar_burst = ar_burst_q;
  assign axi.ar_valid = ar_valid_q;
  assign axi.r_ready  = r_ready_q;
  assign axi.aw_addr  = aw_addr_q;
  assign axi.aw_len   = aw_len_q;
  assign axi.aw_size  = aw_size_q;
  assign axi.aw_burst = aw_burst_q;
  assign axi.aw_valid = aw_valid_q;
  assign axi.w_data   = w_data_q;
  assign axi.w_strb   = w_strb_q;
  assign axi.w_last   = w_last_q;
  assign axi.w_valid  = w_valid_q;
  assign axi.b_ready  = b_ready_q;
  assign c_rready     = c_rready_q;
  assign c_rdata      = line_q;
  assign d_wready     = d_wready_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge (N_RD=2, LINE_BEATS=16): the bench
// plays the AXI slave and the cache clients.
module tb_cache_axi_bridge;
  import cache_axi_pkg::*;

  localparam int N  = 2;
  localparam int LB = 16;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [N*32-1:0] c_raddr;
  logic [N*8-1:0]  c_rlen;
  logic [N*3-1:0]  c_rsize;
  logic [N-1:0]    c_rvalid, c_rready;
  logic [LB*32-1:0] c_rdata, d_wdata;
  logic [31:0]     d_waddr;
  logic [7:0]      d_wlen;
  logic [2:0]      d_wsize;
  logic [3:0]      d_wstrb;
  logic            d_wvalid, d_wready;

  int n_cmp = 0;
  int n_err = 0;
  int rpulse = 0;
  int wpulse = 0;

  cache_axi_bridge_if axi();

  cache_axi_bridge #(.N_RD(N), .LINE_BEATS(LB)) dut (
    .aclk(clk), .aresetn(aresetn), .axi(axi),
    .c_raddr(c_raddr), .c_rlen(c_rlen), .c_rsize(c_rsize),
    .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata),
    .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wlen(d_wlen), .d_wsize(d_wsize),
    .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (c_rready != '0) rpulse <= rpulse + 1;
    if (d_wready) wpulse <= wpulse + 1;
  end

  typedef struct {
    int          cl;
    logic [31:0] addr;
    logic [7:0]  len;
    int          nbeats;
    int          ar_dly;
    logic [31:0] base;
  } rd_vec_t;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [3:0]       strb;
    logic [LB*32-1:0] data;
    int               aw_dly;
    bit               toggle;
    logic [3:0]       exp_strb0;
    logic [31:0]      exp_data0;
  } wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outs"}, {axi.ar_id, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst,
        axi.ar_valid, axi.r_ready, axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst,
        axi.aw_valid, axi.w_data, axi.w_strb, axi.w_last, axi.w_valid, axi.b_ready,
        c_rready, d_wready}, '0);
    chk({name, "_line"}, c_rdata, '0);
  endtask

  task automatic set_client(input int cl, input logic [31:0] addr, input logic [7:0] len);
    c_raddr[cl*32 +: 32] = addr;
    c_rlen[cl*8 +: 8]    = len;
    c_rsize[cl*3 +: 3]   = SIZE_WORD;
  endtask

  // Slave side of one read burst plus completion checks.
  task automatic do_read(input int cl, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input int ar_dly, input logic [31:0] base);
    int t;
    int p0;
    logic [LB*32-1:0] exp_line;
    p0 = rpulse;
    t = 0;
    while (!axi.ar_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!axi.ar_valid) begin
      chk("ar_valid_timeout", axi.ar_valid, 1);
      return;
    end
    c_rvalid[cl] = 1'b0;  // drop request after grant; must not abort
    chk("ar_id", axi.ar_id, cl);
    chk("ar_addr", axi.ar_addr, addr);
    chk("ar_len", axi.ar_len, len);
    chk("ar_size_burst", {axi.ar_size, axi.ar_burst}, {3'd2, 2'b01});
    repeat (ar_dly) @(negedge clk);
    chk("ar_valid_hold", axi.ar_valid, 1);
    axi.ar_ready = 1'b1;
    @(negedge clk);
    axi.ar_ready = 1'b0;
    chk("ar_cleared", {axi.ar_valid, axi.ar_id, axi.ar_addr, axi.ar_len}, '0);
    for (int b = 0; b < nbeats; b++) begin
      chk("r_ready", axi.r_ready, 1);
      axi.r_valid = 1'b1;
      axi.r_data  = base + 32'(b);
      axi.r_last  = (b == nbeats - 1);
      @(negedge clk);
    end
    axi.r_valid = 1'b0;
    axi.r_last  = 1'b0;
    exp_line = '0;
    for (int k = 0; k < LB; k++) begin
      if (k < nbeats) exp_line[k*32 +: 32] = base + 32'(k);
    end
    chk("c_rready_pulse", c_rready, 2'b01 << cl);
    chk("c_rdata", c_rdata, exp_line);
    @(negedge clk);
    chk("c_rready_low", {c_rready, axi.r_ready}, '0);
    chk("c_rdata_hold", c_rdata, exp_line);
    chk("c_rready_count", rpulse - p0, 1);
  endtask

  // Drive one write request and play slave on AW/W/B.
  task automatic do_write(input wr_vec_t v);
    int t;
    int p0;
    logic [31:0] ed;
    logic [3:0]  es;
    p0 = wpulse;
    d_waddr = v.addr; d_wdata = v.data; d_wlen = v.len;
    d_wsize = SIZE_WORD; d_wstrb = v.strb; d_wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!axi.aw_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    d_wvalid = 1'b0;
    if (!axi.aw_valid) begin
      chk("aw_valid_timeout", axi.aw_valid, 1);
      return;
    end
    chk("aw_addr", axi.aw_addr, v.addr);
    chk("aw_len", axi.aw_len, v.len);
    chk("aw_size_burst", {axi.aw_size, axi.aw_burst}, {3'd2, 2'b01});
    repeat (v.aw_dly) @(negedge clk);
    axi.aw_ready = 1'b1;
    @(negedge clk);
    axi.aw_ready = 1'b0;
    chk("aw_cleared", {axi.aw_valid, axi.aw_addr, axi.aw_len}, '0);
    for (int k = 0; k <= int'(v.len); k++) begin
      if (v.len == 8'd0) begin
        ed = v.exp_data0; es = v.exp_strb0;
      end else begin
        ed = v.data[k*32 +: 32]; es = 4'hF;
      end
      if (v.toggle && (k % 2 == 1)) begin
        axi.w_ready = 1'b0;
        @(negedge clk);
        chk("w_stall_hold", {axi.w_valid, axi.w_data}, {1'b1, ed});
      end
      axi.w_ready = 1'b1;
      chk("w_valid", axi.w_valid, 1);
      chk("w_data", axi.w_data, ed);
      chk("w_strb_last", {axi.w_strb, axi.w_last}, {es, (k == int'(v.len))});
      @(negedge clk);
      axi.w_ready = 1'b0;
    end
    chk("b_ready", {axi.b_ready, axi.w_valid}, 2'b10);
    repeat (2) @(negedge clk);
    axi.b_valid = 1'b1;
    @(negedge clk);
    axi.b_valid = 1'b0;
    chk("d_wready_pulse", {d_wready, axi.b_ready}, 2'b10);
    @(negedge clk);
    chk("d_wready_low", d_wready, 0);
    chk("d_wready_count", wpulse - p0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB*32-1:0] line16, line4;
    for (int k = 0; k < LB; k++) begin
      line16[k*32 +: 32] = 32'hD000_0000 + 32'(k);
      line4[k*32 +: 32]  = (k < 4) ? 32'h5000_0000 + 32'(k) : 32'd0;
    end
    rv[0] = '{1, 32'h0000_3000, 8'd3,  4,  0, 32'h0000_00A0};
    rv[1] = '{1, 32'h0000_3100, 8'd17, 18, 1, 32'h0000_0200};
    rv[2] = '{0, 32'h0000_3200, 8'd0,  1,  2, 32'hCAFE_0000};
    rv[3] = '{0, 32'h0000_3300, 8'd7,  8,  0, 32'h0000_0300};
    wv[0] = '{32'h0000_1002, 8'd0,  4'b0011, 512'h0000BEEF, 0, 1'b0, 4'b1100, 32'hBEEF_0000};
    wv[1] = '{32'h0000_2001, 8'd0,  4'b0001, 512'h000000AA, 1, 1'b0, 4'b0010, 32'h0000_AA00};
    wv[2] = '{32'h0000_3003, 8'd0,  4'b1111, 512'h11223344, 0, 1'b0, 4'b1000, 32'h4400_0000};
    wv[3] = '{32'h0000_4000, 8'd15, 4'b1111, line16,        2, 1'b1, 4'hF,    32'd0};
    wv[4] = '{32'h0000_5000, 8'd3,  4'b1111, line4,         0, 1'b0, 4'hF,    32'd0};

    aresetn = 1'b0;
    c_raddr = '0; c_rlen = '0; c_rsize = '0; c_rvalid = '0;
    d_waddr = '0; d_wdata = '0; d_wlen = '0; d_wsize = '0; d_wstrb = '0; d_wvalid = 1'b0;
    axi.ar_ready = 1'b0; axi.r_id = '0; axi.r_data = '0; axi.r_last = 1'b0; axi.r_valid = 1'b0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    aresetn = 1'b1;
    @(negedge clk);

    // Both clients request at rr_ptr=0: client 0 first, then client 1.
    set_client(0, 32'h0000_1000, 8'd15);
    set_client(1, 32'h0000_2000, 8'd15);
    c_rvalid = 2'b11;
    do_read(0, 32'h0000_1000, 8'd15, 16, 0, 32'h0000_0100);
    do_read(1, 32'h0000_2000, 8'd15, 16, 3, 32'd0);

    for (int i = 0; i < 4; i++) begin
      set_client(rv[i].cl, rv[i].addr, rv[i].len);
      c_rvalid[rv[i].cl] = 1'b1;
      do_read(rv[i].cl, rv[i].addr, rv[i].len, rv[i].nbeats, rv[i].ar_dly, rv[i].base);
    end

    for (int i = 0; i < 5; i++) do_write(wv[i]);

    // Reset in the middle of a read burst and a write burst.
    set_client(0, 32'h0000_7000, 8'd15);
    c_rvalid = 2'b01;
    d_waddr = 32'h0000_8000; d_wdata = line16; d_wlen = 8'd15; d_wstrb = 4'hF;
    d_wsize = SIZE_WORD; d_wvalid = 1'b1;
    axi.ar_ready = 1'b1; axi.aw_ready = 1'b1;
    @(negedge clk);
    c_rvalid = 2'b00; d_wvalid = 1'b0;
    @(negedge clk);
    axi.ar_ready = 1'b0; axi.aw_ready = 1'b0;
    axi.r_valid = 1'b1; axi.r_data = 32'h55; axi.r_last = 1'b0; axi.w_ready = 1'b1;
    @(negedge clk);
    chk("mid_busy", {axi.r_ready, axi.w_valid, (c_rdata != '0)}, 3'b111);
    #2 aresetn = 1'b0;
    #1 check_all_zero("async_rst");
    axi.r_valid = 1'b0; axi.w_ready = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // rr_ptr must be back at 0 after reset.
    set_client(0, 32'h0000_9000, 8'd1);
    set_client(1, 32'h0000_A000, 8'd1);
    c_rvalid = 2'b11;
    do_read(0, 32'h0000_9000, 8'd1, 2, 0, 32'h0000_0900);
    do_read(1, 32'h0000_A000, 8'd1, 2, 1, 32'h0000_0A00);
    do_write(wv[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 Parameter N_RD, default 2: number of cache read clients (1..8); a client's index is its AXI ARID.
REQ-002 Parameter LINE_BEATS, default 16: 32-bit words per cache line (power of two, 1..16).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 aclk  in  1  clock, all logic rising-edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_valid  out  4/32/8/3/2/1  AXI read-address channel; ar_ready  in  1.
REQ-007 r_id/r_data/r_last/r_valid  in  4/32/1/1  AXI read-data channel; r_ready  out  1.
REQ-008 aw_addr/aw_len/aw_size/aw_burst/aw_valid  out  32/8/3/2/1  AXI write-address channel; aw_ready  in  1.
REQ-009 w_data/w_strb/w_last/w_valid  out  32/4/1/1  AXI write-data channel; w_ready  in  1; b_valid  in  1; b_ready  out  1.
REQ-010 c_raddr/c_rlen/c_rsize  in  N_RD*32/N_RD*8/N_RD*3  packed per-client read request fields (client k at slice k).
REQ-011 c_rvalid  in  N_RD  per-client request; c_rready  out  N_RD  per-client one-cycle completion pulse.
REQ-012 c_rdata  out  LINE_BEATS*32  returned line, shared by all clients, beat k at bits [32k+31:32k].
REQ-013 d_waddr/d_wdata/d_wlen/d_wsize/d_wstrb/d_wvalid  in  32/LINE_BEATS*32/8/3/4/1  write request; d_wready  out  1  one-cycle completion pulse.

Function
REQ-014 The read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_DONE; the write FSM SHALL have W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE; the two SHALL run independently and concurrently.
REQ-015 In R_IDLE with any c_rvalid high, the grant SHALL be the first requesting client at or after rr_ptr (round-robin, wrapping at N_RD); addr/len/size/index SHALL be latched and the FSM moves to R_ADDR next cycle.
REQ-016 In R_ADDR, ar_valid=1 with latched fields stable, ar_id=grant, ar_burst=INCR; on ar_valid&ar_ready -> R_DATA.
REQ-017 In R_DATA, r_ready=1; each accepted beat SHALL be written at beat index cnt, cnt increments; beats with cnt>=LINE_BEATS are discarded (cnt saturates); r_id is not checked (one read outstanding).
REQ-018 On accepted beat with r_last -> R_DONE; in R_DONE c_rready[grant]=1 for exactly one cycle with c_rdata valid, rr_ptr<=(grant+1) mod N_RD, -> R_IDLE.
REQ-019 Line buffer beats not written by the burst SHALL read zero (cleared at grant); c_rdata holds its value until the next grant.
REQ-020 Dropping c_rvalid after grant SHALL NOT abort the transaction; c_rready still pulses.
REQ-021 In W_IDLE with d_wvalid, all write inputs SHALL be latched -> W_ADDR; aw_valid=1 there; on aw_ready -> W_DATA.
REQ-022 In W_DATA, w_valid=1, w_data=beat[wcnt], w_last=(wcnt==latched len); wcnt advances only on w_valid&w_ready; on last accepted -> W_RESP.
REQ-023 For len==0 (uncached single beat) w_strb SHALL be d_wstrb<<addr[1:0] and w_data beat0<<(8*addr[1:0]); for len>0 w_strb=4'hF.
REQ-024 In W_RESP b_ready=1; on b_valid -> W_DONE; d_wready=1 for exactly one cycle, -> W_IDLE.
REQ-025 Minimum read latency grant-to-c_rready: 3 cycles + AR wait + beats; write latency likewise via aw/w/b waits.
REQ-026 While not in their address states, ar_valid/aw_valid SHALL be 0 and all AR/AW field outputs 0.

Reset
REQ-027 aresetn low SHALL immediately force R_IDLE, W_IDLE, rr_ptr=0, cnt=wcnt=0, line buffer 0, and every output 0, including mid-burst; in-flight AXI transactions are abandoned.

Structure
REQ-028 Package cache_axi_pkg SHALL hold both FSM state enumerations, BURST_INCR=2'b01, SIZE_WORD=3'd2, ID width 4.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (N requests, pointer in, one-hot grant and index out, combinational).

Verification
REQ-030 N_RD=2: c_rvalid=2'b11 at rr_ptr=0 -> client 0 served, ar_id=0; then client 1 served, ar_id=1.
REQ-031 Read 16 beats data=beat index, ar_ready delayed 3 cycles -> c_rdata word k==k, single c_rready pulse.
REQ-032 Burst with r_last at beat 4 (len=3) -> words 4..15 read zero.
REQ-033 Write len=0, addr=0x...2, strb=4'b0011, data=0x0000BEEF -> w_strb=4'b1100, w_data=0xBEEF0000, w_last=1.
REQ-034 Write len=15 with w_ready toggling -> 16 beats in order, one d_wready pulse after b_valid.
REQ-035 aresetn low mid R_DATA and mid W_DATA -> all outputs 0 same cycle, FSMs idle; next request completes normally.
